tagged_btb: RTL and testbench

TAGGED_BTB -- requirements
Module: tagged_btb

---
 rtl/tagged_btb_if.sv | 40 ++++
 rtl/tagged_btb.sv | 224 ++++++++++++++++++++++
 tb/tb_tagged_btb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tagged_btb_if.sv
// Bus bundle for the tagged BTB: fetch-group lookup request, registered
// response, resolved-branch update and whole-table invalidate.
interface tagged_btb_if #(
  parameter int FETCH_WIDTH = 4
) ();
  localparam int IDX_W = $clog2(FETCH_WIDTH);

  logic                      req_valid_i;
  logic [31:0]               req_pc_i;
  logic [FETCH_WIDTH-1:0]    req_slot_en_i;
  logic                      req_ready_o;

  logic                      resp_valid_o;
  logic [FETCH_WIDTH-1:0]    resp_hit_o;
  logic [FETCH_WIDTH-1:0]    resp_take_o;
  logic [FETCH_WIDTH*32-1:0] resp_dest_o;
  logic                      resp_first_take_o;
  logic [IDX_W-1:0]          resp_first_idx_o;
  logic [31:0]               resp_next_pc_o;

  logic                      upd_valid_i;
  logic [31:0]               upd_pc_i;
  logic                      upd_taken_i;
  logic [31:0]               upd_dest_i;
  logic                      inv_all_i;

  modport master (
    output req_valid_i, req_pc_i, req_slot_en_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_dest_i, inv_all_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_take_o, resp_dest_o,
    input  resp_first_take_o, resp_first_idx_o, resp_next_pc_o
  );

  modport slave (
    input  req_valid_i, req_pc_i, req_slot_en_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_dest_i, inv_all_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_take_o, resp_dest_o,
    output resp_first_take_o, resp_first_idx_o, resp_next_pc_o
  );
endinterface

// File: rtl/tagged_btb.sv
// Banked, partially tagged branch target buffer. One bank per fetch slot,
// each bank holds SETS entries of {valid, tag, dest[31:2], 2-bit counter}.
// Lookups return one cycle later; an INIT sweep clears valid after reset or
// a flush, one set per cycle across all banks.
module tagged_btb #(
  parameter int FETCH_WIDTH = 4,
  parameter int SETS        = 256,
  parameter int TAG_BITS    = 8
) (
  input logic         clk,
  input logic         rst,
  tagged_btb_if.slave bus
);
  localparam int BANK_BITS = $clog2(FETCH_WIDTH);
  localparam int SET_BITS  = $clog2(SETS);
  localparam int SET_LSB   = BANK_BITS + 2;
  localparam int TAG_LSB   = SET_LSB + SET_BITS;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  // Two-bit saturating counter step: up on taken, down on not-taken.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    if (taken) begin
      if (ctr == 2'b11) r = 2'b11;
      else              r = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) r = 2'b00;
      else              r = ctr - 2'b01;
    end
    return r;
  endfunction

  // Table storage; payloads are never reset, valid is cleared by the sweep.
  logic                valid_q [FETCH_WIDTH][SETS];
  logic [TAG_BITS-1:0] tag_q   [FETCH_WIDTH][SETS];
  logic [29:0]         dest_q  [FETCH_WIDTH][SETS];
  logic [1:0]          ctr_q   [FETCH_WIDTH][SETS];

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;

  logic                      resp_valid_q, resp_valid_d;
  logic [FETCH_WIDTH-1:0]    resp_hit_q, resp_hit_d;
  logic [FETCH_WIDTH-1:0]    resp_take_q, resp_take_d;
  logic [FETCH_WIDTH*32-1:0] resp_dest_q, resp_dest_d;
  logic                      resp_first_take_q, resp_first_take_d;
  logic [BANK_BITS-1:0]      resp_first_idx_q, resp_first_idx_d;
  logic [31:0]               resp_next_pc_q, resp_next_pc_d;

  logic                      accept_s;
  logic [SET_BITS-1:0]       lk_set_s;
  logic [TAG_BITS-1:0]       lk_tag_s;
  logic [FETCH_WIDTH-1:0]    lk_hit_s, lk_take_s;
  logic [FETCH_WIDTH*32-1:0] lk_dest_s;
  logic                      lk_first_take_s;
  logic [BANK_BITS-1:0]      lk_first_idx_s;
  logic [31:0]               lk_next_pc_s;

  logic [BANK_BITS-1:0]      upd_bank_s;
  logic [SET_BITS-1:0]       upd_set_s;
  logic [TAG_BITS-1:0]       upd_tag_s;
  logic                      upd_go_s, upd_hit_s;
  logic                      wr_en_s;
  logic [29:0]               wr_dest_s;
  logic [1:0]                wr_ctr_s;

  assign accept_s        = bus.req_valid_i && (state_q == ST_RUN);
  assign bus.req_ready_o = (state_q == ST_RUN);

  // INIT/RUN sequencing: sweep every set once, restart on flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (bus.inv_all_i) begin
          cnt_d = '0;
        end else if (&cnt_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_BITS'(1);
        end
      end
      ST_RUN: begin
        if (bus.inv_all_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-slot lookup; the base is group-aligned so slot k always lives in bank k.
  always_comb begin
    lk_set_s        = bus.req_pc_i[TAG_LSB-1:SET_LSB];
    lk_tag_s        = bus.req_pc_i[TAG_LSB+TAG_BITS-1:TAG_LSB];
    lk_hit_s        = '0;
    lk_take_s       = '0;
    lk_dest_s       = '0;
    lk_first_take_s = 1'b0;
    lk_first_idx_s  = '0;
    lk_next_pc_s    = bus.req_pc_i + 32'(4 * FETCH_WIDTH);
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lk_hit_s[k]  = valid_q[k][lk_set_s] && (tag_q[k][lk_set_s] == lk_tag_s);
      lk_take_s[k] = lk_hit_s[k] && ctr_q[k][lk_set_s][1] && bus.req_slot_en_i[k];
      if (lk_take_s[k]) lk_dest_s[32*k +: 32] = {dest_q[k][lk_set_s], 2'b00};
      else              lk_dest_s[32*k +: 32] = bus.req_pc_i + 32'(4 * k + 8);
    end
    // Scan high to low so the lowest taken slot wins.
    for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
      if (lk_take_s[k]) begin
        lk_first_take_s = 1'b1;
        lk_first_idx_s  = BANK_BITS'(k);
        lk_next_pc_s    = lk_dest_s[32*k +: 32];
      end else begin
        lk_first_take_s = lk_first_take_s;
      end
    end
  end

  // Response capture: refresh on an accepted request, otherwise hold.
  always_comb begin
    resp_valid_d      = accept_s;
    resp_hit_d        = resp_hit_q;
    resp_take_d       = resp_take_q;
    resp_dest_d       = resp_dest_q;
    resp_first_take_d = resp_first_take_q;
    resp_first_idx_d  = resp_first_idx_q;
    resp_next_pc_d    = resp_next_pc_q;
    if (accept_s) begin
      resp_hit_d        = lk_hit_s;
      resp_take_d       = lk_take_s;
      resp_dest_d       = lk_dest_s;
      resp_first_take_d = lk_first_take_s;
      resp_first_idx_d  = lk_first_idx_s;
      resp_next_pc_d    = lk_next_pc_s;
    end else begin
      resp_valid_d = 1'b0;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid_q      <= 1'b0;
      resp_hit_q        <= '0;
      resp_take_q       <= '0;
      resp_dest_q       <= '0;
      resp_first_take_q <= 1'b0;
      resp_first_idx_q  <= '0;
      resp_next_pc_q    <= 32'h0000_0000;
    end else begin
      resp_valid_q      <= resp_valid_d;
      resp_hit_q        <= resp_hit_d;
      resp_take_q       <= resp_take_d;
      resp_dest_q       <= resp_dest_d;
      resp_first_take_q <= resp_first_take_d;
      resp_first_idx_q  <= resp_first_idx_d;
      resp_next_pc_q    <= resp_next_pc_d;
    end
  end

  assign bus.resp_valid_o      = resp_valid_q;
  assign bus.resp_hit_o        = resp_hit_q;
  assign bus.resp_take_o       = resp_take_q;
  assign bus.resp_dest_o       = resp_dest_q;
  assign bus.resp_first_take_o = resp_first_take_q;
  assign bus.resp_first_idx_o  = resp_first_idx_q;
  assign bus.resp_next_pc_o    = resp_next_pc_q;

  // Update decode: train a hit, allocate a taken miss, ignore a not-taken miss.
  always_comb begin
    upd_bank_s = bus.upd_pc_i[SET_LSB-1:2];
    upd_set_s  = bus.upd_pc_i[TAG_LSB-1:SET_LSB];
    upd_tag_s  = bus.upd_pc_i[TAG_LSB+TAG_BITS-1:TAG_LSB];
    upd_go_s   = bus.upd_valid_i && (state_q == ST_RUN) && !bus.inv_all_i;
    upd_hit_s  = valid_q[upd_bank_s][upd_set_s] && (tag_q[upd_bank_s][upd_set_s] == upd_tag_s);
    wr_en_s    = 1'b0;
    wr_dest_s  = bus.upd_dest_i[31:2];
    wr_ctr_s   = 2'b10;
    if (upd_go_s && upd_hit_s) begin
      wr_en_s  = 1'b1;
      wr_ctr_s = ctr_step(ctr_q[upd_bank_s][upd_set_s], bus.upd_taken_i);
      if (bus.upd_taken_i) wr_dest_s = bus.upd_dest_i[31:2];
      else                 wr_dest_s = dest_q[upd_bank_s][upd_set_s];
    end else if (upd_go_s && bus.upd_taken_i) begin
      wr_en_s  = 1'b1;
      wr_ctr_s = 2'b10;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Table writes: sweep clears one set in every bank, otherwise apply the update.
  always_ff @(posedge clk) begin
    if (rst && (state_q == ST_INIT)) begin
      for (int b = 0; b < FETCH_WIDTH; b++) valid_q[b][cnt_q] <= 1'b0;
    end else if (rst && wr_en_s) begin
      valid_q[upd_bank_s][upd_set_s] <= 1'b1;
      tag_q[upd_bank_s][upd_set_s]   <= upd_tag_s;
      dest_q[upd_bank_s][upd_set_s]  <= wr_dest_s;
      ctr_q[upd_bank_s][upd_set_s]   <= wr_ctr_s;
    end
  end
endmodule

// File: tb/tb_tagged_btb.sv
// Directed bench for tagged_btb (FW=4, SETS=256, TAG_BITS=8).
// Expected responses are queued when a request is driven and checked when
// the response comes out one cycle later.
module tb_tagged_btb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tagged_btb_if #(.FETCH_WIDTH(4)) bus ();

  tagged_btb #(.FETCH_WIDTH(4), .SETS(256), .TAG_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]   hit;
    logic [3:0]   take;
    logic [127:0] dest;
    logic         first_take;
    logic [1:0]   first_idx;
    logic [31:0]  next_pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Build an expected response from the per-slot hit/take pattern and the taken targets.
  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] hit, input logic [3:0] take,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    exp_t e;
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    e.hit        = hit;
    e.take       = take;
    e.first_take = 1'b0;
    e.first_idx  = 2'd0;
    e.next_pc    = pc + 32'd16;
    for (int k = 0; k < 4; k++)
      e.dest[32*k +: 32] = take[k] ? d[k] : pc + 32'(4 * k) + 32'd8;
    for (int k = 3; k >= 0; k--)
      if (take[k]) begin
        e.first_take = 1'b1;
        e.first_idx  = 2'(k);
        e.next_pc    = d[k];
      end
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    check("resp_valid", 128'(bus.resp_valid_o), 128'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("resp_hit",        128'(bus.resp_hit_o),        128'(e.hit));
      check("resp_take",       128'(bus.resp_take_o),       128'(e.take));
      check("resp_dest",       bus.resp_dest_o,             e.dest);
      check("resp_first_take", 128'(bus.resp_first_take_o), 128'(e.first_take));
      check("resp_first_idx",  128'(bus.resp_first_idx_o),  128'(e.first_idx));
      check("resp_next_pc",    128'(bus.resp_next_pc_o),    128'(e.next_pc));
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [3:0] en, input exp_t e);
    bus.req_valid_i   = 1'b1;
    bus.req_pc_i      = pc;
    bus.req_slot_en_i = en;
    exp_q.push_back(e);
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] dest);
    bus.upd_valid_i = 1'b1;
    bus.upd_pc_i    = pc;
    bus.upd_taken_i = taken;
    bus.upd_dest_i  = dest;
    tick();
    bus.upd_valid_i = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check(tag, 128'(n), 128'(exp_n));
  endtask

  task automatic check_zero_resp(input string tag);
    check({tag, "_valid"}, 128'(bus.resp_valid_o), 128'(0));
    check({tag, "_hit"},   128'(bus.resp_hit_o),   128'(0));
    check({tag, "_take"},  128'(bus.resp_take_o),  128'(0));
    check({tag, "_dest"},  bus.resp_dest_o,        128'(0));
    check({tag, "_first"}, 128'(bus.resp_first_take_o), 128'(0));
    check({tag, "_idx"},   128'(bus.resp_first_idx_o),  128'(0));
    check({tag, "_npc"},   128'(bus.resp_next_pc_o),    128'(0));
  endtask

  initial begin
    rst               = 1'b0;
    bus.req_valid_i   = 1'b0;
    bus.req_pc_i      = 32'h0000_0000;
    bus.req_slot_en_i = 4'b0000;
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = 32'h0000_0000;
    bus.upd_taken_i   = 1'b0;
    bus.upd_dest_i    = 32'h0000_0000;
    bus.inv_all_i     = 1'b0;

    // Reset state, then the 256-cycle sweep with ready low.
    repeat (3) tick();
    check("reset_ready", 128'(bus.req_ready_o), 128'(0));
    check_zero_resp("reset");
    rst = 1'b1;
    wait_ready("init_ready_low_cycles", 256);

    // Empty table misses everywhere.
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0000, 4'b0000, 0, 0, 0, 0));

    // Allocate slot 2 and look it up; outputs then hold for an idle cycle.
    update(32'h0000_1008, 1'b1, 32'h0000_2000);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0100, 4'b0100, 0, 0, 32'h2000, 0));
    tick();
    check("hold_next_pc", 128'(bus.resp_next_pc_o), 128'(32'h0000_2000));
    check("hold_take",    128'(bus.resp_take_o),    128'(4'b0100));

    // Different tag misses; bit 20 lies above the 8-bit tag so 0x00101000 aliases 0x00001000.
    lookup(32'h0001_1000, 4'b1111, mk(32'h0001_1000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    lookup(32'h0010_1000, 4'b1111, mk(32'h0010_1000, 4'b0100, 4'b0100, 0, 0, 32'h2000, 0));

    // Counter training: 10 -> 01 -> 00 (floor) -> 01 -> 10 -> 11 (ceiling) -> 10 -> 01.
    update(32'h0000_1008, 1'b0, 32'h0000_3330);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0100, 4'b0000, 0, 0, 0, 0));
    update(32'h0000_1008, 1'b0, 32'h0000_3330);
    update(32'h0000_1008, 1'b0, 32'h0000_3330);
    update(32'h0000_1008, 1'b1, 32'h0000_2000);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0100, 4'b0000, 0, 0, 0, 0));
    update(32'h0000_1008, 1'b1, 32'h0000_2000);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0100, 4'b0100, 0, 0, 32'h2000, 0));
    update(32'h0000_1008, 1'b1, 32'h0000_2000);
    update(32'h0000_1008, 1'b1, 32'h0000_2000);
    update(32'h0000_1008, 1'b1, 32'h0000_2000);
    update(32'h0000_1008, 1'b0, 32'h0000_3330);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0100, 4'b0100, 0, 0, 32'h2000, 0));
    update(32'h0000_1008, 1'b0, 32'h0000_3330);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0100, 4'b0000, 0, 0, 0, 0));

    // First-taken selection with slot enables (slot 2 is weakly not-taken here).
    update(32'h0000_1004, 1'b1, 32'h0000_4000);
    update(32'h0000_100C, 1'b1, 32'h0000_5000);
    lookup(32'h0000_1000, 4'b1101, mk(32'h0000_1000, 4'b1110, 4'b1000, 0, 0, 0, 32'h5000));
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b1110, 4'b1010, 0, 32'h4000, 0, 32'h5000));
    lookup(32'h0000_1000, 4'b0000, mk(32'h0000_1000, 4'b1110, 4'b0000, 0, 0, 0, 0));

    // Update and lookup to the same entry in one cycle: old contents first, new after.
    bus.upd_valid_i = 1'b1;
    bus.upd_pc_i    = 32'h0000_1008;
    bus.upd_taken_i = 1'b1;
    bus.upd_dest_i  = 32'h0000_6000;
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b1110, 4'b1010, 0, 32'h4000, 0, 32'h5000));
    bus.upd_valid_i = 1'b0;
    lookup(32'h0000_1000, 4'b1111,
           mk(32'h0000_1000, 4'b1110, 4'b1110, 0, 32'h4000, 32'h6000, 32'h5000));

    // Not-taken miss allocates nothing; next_pc wraps at the top of the address space.
    update(32'h0000_2000, 1'b0, 32'h0000_9000);
    lookup(32'h0000_2000, 4'b1111, mk(32'h0000_2000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    lookup(32'hFFFF_FFF0, 4'b1111, mk(32'hFFFF_FFF0, 4'b0000, 4'b0000, 0, 0, 0, 0));

    // Flush from RUN (with a coincident update), restart mid-sweep, update during INIT.
    bus.inv_all_i = 1'b1;
    update(32'h0000_1008, 1'b1, 32'h0000_7000);
    bus.inv_all_i = 1'b0;
    check("inv_ready_low", 128'(bus.req_ready_o), 128'(0));
    repeat (100) tick();
    bus.inv_all_i = 1'b1;
    tick();
    bus.inv_all_i = 1'b0;
    repeat (150) tick();
    update(32'h0000_1008, 1'b1, 32'h0000_8000);
    wait_ready("restart_ready_low_cycles", 105);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0000, 4'b0000, 0, 0, 0, 0));

    // Entry allocated again, then reset in RUN with a coincident request gives no response.
    update(32'h0000_1000, 1'b1, 32'h0000_A000);
    lookup(32'h0000_1000, 4'b1111, mk(32'h0000_1000, 4'b0001, 4'b0001, 32'hA000, 0, 0, 0));
    rst             = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_pc_i    = 32'h0000_1000;
    tick();
    bus.req_valid_i = 1'b0;
    check_zero_resp("midrun_reset");
    rst = 1'b1;
    check("midrun_reset_ready", 128'(bus.req_ready_o), 128'(0));
    wait_ready("post_reset_ready_low_cycles", 256);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
